fpu_pipe_ctrl: RTL and testbench

FPU_PIPE_CTRL -- requirements
Module: fpu_pipe_ctrl

---
 rtl/fpu_pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_fpu_pipe_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe_ctrl.sv
// fpu_pipe_ctrl
//   Pipeline control for a floating-point unit. It tracks the destination
//   register number and write flag of each execute stage E1..E_DEPTH and of
//   writeback, and detects source/destination hazards for the instruction in
//   ID. It also counts the occupancy of the iterative fdiv/fsqrt unit.
//
//   Optional feature macro: FPU_FWD_EN
//     defined   : a hazard on E_DEPTH forwards res_in (fwd=01), a hazard on W
//                 forwards wd (fwd=10), and only E1..E_DEPTH-1 stall.
//     undefined : any hazard in E1..E_DEPTH stalls, and fwd_a/fwd_b are 00.
//
//   Ports
//     clk, clrn       clock, synchronous active-low reset
//     fs, ft, use_*   ID source register numbers and their read enables
//     fd, wf, fc      ID destination, fp write enable, op code
//     ein1            no cache stall
//     ein2            cancel for the E1 instruction (0 = cancel)
//     res_in          arithmetic result at stage E_DEPTH
//     en, ew          per-stage destination / write flag, E1 in the low slot
//     wn, ww, wd      writeback register number, enable, data
//     e               pipeline advance
//     st_ds, st_raw   fdiv/fsqrt stall, hazard stall
//     fwd_a, fwd_b    operand source select (00 regfile, 01 res_in, 10 wd)
module fpu_pipe_ctrl #(
    parameter int W      = 32,
    parameter int AW     = 5,
    parameter int DEPTH  = 3,
    parameter int DS_LAT = 14
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [AW-1:0]         fs,
    input  logic [AW-1:0]         ft,
    input  logic                  use_fs,
    input  logic                  use_ft,
    input  logic [AW-1:0]         fd,
    input  logic                  wf,
    input  logic [2:0]            fc,
    input  logic                  ein1,
    input  logic                  ein2,
    input  logic [W-1:0]          res_in,
    output logic [DEPTH*AW-1:0]   en,
    output logic [DEPTH-1:0]      ew,
    output logic [AW-1:0]         wn,
    output logic                  ww,
    output logic [W-1:0]          wd,
    output logic                  e,
    output logic                  st_ds,
    output logic                  st_raw,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam int CW = $clog2(DS_LAT);

    logic [DEPTH-1:0][AW-1:0] en_q;
    logic [DEPTH-1:0]         ew_q;   // ew_q[0] is the raw E1 flag, before ein2
    logic [DEPTH-1:0]         ew_g;   // write flags as seen by the rest of the pipe
    logic                     e1_ds;  // E1 holds an fdiv/fsqrt issued last cycle
    logic [CW-1:0]            ds_cnt;
    logic                     is_ds;
    logic                     issue_ds;
    logic                     ds_cancel;
    logic                     hit_a;
    logic                     hit_b;

    assign ew_g      = {ew_q[DEPTH-1:1], ew_q[0] & ein2};
    assign ew        = ew_g;
    assign en        = en_q;
    assign st_ds     = (ds_cnt != '0);
    assign e         = ein1 & ~st_ds;
    assign is_ds     = (fc == 3'b100) || (fc == 3'b101);
    assign issue_ds  = e & ~st_raw & is_ds;
    assign ds_cancel = e1_ds & ~ein2;

    // Hazard search, youngest stage first; the first hit decides.
    always_comb begin
        st_raw = 1'b0;
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit_a && use_fs && ew_g[k] && (en_q[k] == fs)) begin
                hit_a = 1'b1;
`ifdef FPU_FWD_EN
                if (k == DEPTH-1) fwd_a = 2'b01;
                else              st_raw = 1'b1;
`else
                st_raw = 1'b1;
`endif
            end
            if (!hit_b && use_ft && ew_g[k] && (en_q[k] == ft)) begin
                hit_b = 1'b1;
`ifdef FPU_FWD_EN
                if (k == DEPTH-1) fwd_b = 2'b01;
                else              st_raw = 1'b1;
`else
                st_raw = 1'b1;
`endif
            end
        end
`ifdef FPU_FWD_EN
        // W writes the regfile in the same cycle ID reads it, so a W hit
        // only matters for forwarding.
        if (!hit_a && use_fs && ww && (wn == fs)) fwd_a = 2'b10;
        if (!hit_b && use_ft && ww && (wn == ft)) fwd_b = 2'b10;
`endif
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            en_q   <= '0;
            ew_q   <= '0;
            wn     <= '0;
            ww     <= 1'b0;
            wd     <= '0;
            e1_ds  <= 1'b0;
            ds_cnt <= '0;
        end else begin
            e1_ds <= issue_ds;
            if (ds_cancel)      ds_cnt <= '0;
            else if (issue_ds)  ds_cnt <= CW'(DS_LAT-1);
            else if (st_ds)     ds_cnt <= ds_cnt - CW'(1);

            if (e) begin
                en_q[0] <= st_raw ? '0 : fd;
                ew_q[0] <= wf & ~st_raw;
                for (int k = 1; k < DEPTH; k++) begin
                    en_q[k] <= en_q[k-1];
                    ew_q[k] <= ew_g[k-1];
                end
                wn <= en_q[DEPTH-1];
                ww <= ew_g[DEPTH-1];
                wd <= res_in;
            end else if (ds_cancel) begin
                // A cancelled fdiv/fsqrt sits in E1 for the rest of the stall;
                // drop its write flag so it cannot reappear when ein2 returns.
                ew_q[0] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
module tb_fpu_pipe_ctrl;
    localparam int W = 32, AW = 5, DEPTH = 3, DS_LAT = 14;

    logic clk = 1'b0, clrn;
    logic [AW-1:0] fs, ft, fd;
    logic use_fs, use_ft, wf, ein1, ein2;
    logic [2:0] fc;
    logic [W-1:0] res_in;
    logic [DEPTH*AW-1:0] en;
    logic [DEPTH-1:0] ew;
    logic [AW-1:0] wn;
    logic ww, e, st_ds, st_raw;
    logic [W-1:0] wd;
    logic [1:0] fwd_a, fwd_b;

    int checks = 0, errors = 0;

    fpu_pipe_ctrl #(.W(W), .AW(AW), .DEPTH(DEPTH), .DS_LAT(DS_LAT)) dut (
        .clk(clk), .clrn(clrn), .fs(fs), .ft(ft), .use_fs(use_fs), .use_ft(use_ft),
        .fd(fd), .wf(wf), .fc(fc), .ein1(ein1), .ein2(ein2), .res_in(res_in),
        .en(en), .ew(ew), .wn(wn), .ww(ww), .wd(wd), .e(e), .st_ds(st_ds),
        .st_raw(st_raw), .fwd_a(fwd_a), .fwd_b(fwd_b));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each stage holds an "instruction": its destination and whether it will
    // write. Index 0 is E1. The divider is just a count of remaining busy cycles.
    typedef struct packed { logic [AW-1:0] dst; logic wr; } ins_t;
    ins_t         stg [DEPTH];
    ins_t         m_w;
    logic [W-1:0] m_wd;
    int           m_busy;
    bit           m_just_issued_ds;

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) stg[k] = '0;
        m_w = '0; m_wd = '0; m_busy = 0; m_just_issued_ds = 0;
    endtask

    function automatic bit m_writes(int k);
        return (k == 0) ? (stg[0].wr & ein2) : stg[k].wr;
    endfunction

    task automatic m_hazard(input logic [AW-1:0] src, input logic use_src,
                            output bit stall, output logic [1:0] fw);
        bit found = 0;
        stall = 0; fw = 2'b00;
        if (use_src) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && m_writes(k) && stg[k].dst == src) begin
                    found = 1;
`ifdef FPU_FWD_EN
                    if (k == DEPTH-1) fw = 2'b01; else stall = 1;
`else
                    stall = 1;
`endif
                end
            end
`ifdef FPU_FWD_EN
            if (!found && m_w.wr && m_w.dst == src) fw = 2'b10;
`endif
        end
    endtask

    task automatic m_comb(output bit xe, output bit xds, output bit xraw,
                          output logic [1:0] xfa, output logic [1:0] xfb);
        bit sa, sb;
        m_hazard(fs, use_fs, sa, xfa);
        m_hazard(ft, use_ft, sb, xfb);
        xraw = sa | sb;
        xds  = (m_busy > 0);
        xe   = ein1 & !xds;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        bit xe, xds, xraw; logic [1:0] xfa, xfb;
        ins_t nx [DEPTH];
        bit issue, cancel;
        m_comb(xe, xds, xraw, xfa, xfb);
        if (!clrn) begin
            model_reset();
            return;
        end
        issue  = xe && !xraw && (fc == 3'b100 || fc == 3'b101);
        cancel = m_just_issued_ds && !ein2;
        if (cancel)         m_busy = 0;
        else if (issue)     m_busy = DS_LAT - 1;
        else if (m_busy>0)  m_busy = m_busy - 1;
        m_just_issued_ds = issue;
        if (xe) begin
            m_w.dst = stg[DEPTH-1].dst; m_w.wr = m_writes(DEPTH-1); m_wd = res_in;
            for (int k = 1; k < DEPTH; k++) begin
                nx[k].dst = stg[k-1].dst; nx[k].wr = m_writes(k-1);
            end
            nx[0].dst = xraw ? '0 : fd; nx[0].wr = wf & !xraw;
            for (int k = 0; k < DEPTH; k++) stg[k] = nx[k];
        end else if (cancel) begin
            stg[0].wr = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_idle();
        fs = '0; ft = '0; fd = '0; use_fs = 0; use_ft = 0; wf = 0;
        fc = 3'b111; ein1 = 1; ein2 = 1; res_in = '0;
    endtask

    task automatic do_reset();
        set_idle(); clrn = 0; tick(); tick(); clrn = 1; #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (en !== '0) begin errors++; $display("FAIL reset_en got %h want 0", en); end
        checks++; if (ew !== '0) begin errors++; $display("FAIL reset_ew got %b want 0", ew); end
        checks++; if ({wn, ww} !== '0) begin errors++; $display("FAIL reset_w got wn=%0d ww=%b want 0", wn, ww); end
        checks++; if (wd !== '0) begin errors++; $display("FAIL reset_wd got %h want 0", wd); end
        checks++; if ({st_ds, st_raw, fwd_a, fwd_b} !== 6'b0) begin errors++;
            $display("FAIL reset_stall got ds=%b raw=%b fa=%b fb=%b want 0", st_ds, st_raw, fwd_a, fwd_b); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL reset_e got %b want 1", e); end
    endtask

    task automatic test_latency();
        logic [W-1:0] r;
        do_reset();
        fd = 5; wf = 1; fc = 3'b000; res_in = $urandom; tick();
        checks++; if (en[AW-1:0] !== 5 || ew[0] !== 1'b1) begin errors++;
            $display("FAIL lat_e1 got en=%0d ew=%b want 5/1", en[AW-1:0], ew[0]); end
        set_idle(); res_in = $urandom; tick();
        res_in = $urandom; tick();
        checks++; if (en[3*AW-1:2*AW] !== 5 || ew[2] !== 1'b1) begin errors++;
            $display("FAIL lat_e3 got en=%0d ew=%b want 5/1", en[3*AW-1:2*AW], ew[2]); end
        r = $urandom; res_in = r; #1;
        checks++; if (ww !== 1'b0) begin errors++; $display("FAIL lat_early got ww=%b want 0", ww); end
        tick();
        checks++; if (ww !== 1'b1 || wn !== 5 || wd !== r) begin errors++;
            $display("FAIL lat_wb got ww=%b wn=%0d wd=%h want 1/5/%h", ww, wn, wd, r); end
    endtask

    task automatic test_fdiv();
        int bad = 0;
        do_reset();
        fc = 3'b100; fd = 3; wf = 1; #1;
        checks++; if (e !== 1'b1 || st_ds !== 1'b0) begin errors++;
            $display("FAIL ds_pre got e=%b st_ds=%b want 1/0", e, st_ds); end
        tick();
        set_idle();
        for (int i = 0; i < DS_LAT-1; i++) begin
            #1; if (st_ds !== 1'b1 || e !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ds_busy got %0d bad cycles want 0", bad); end
        checks++; if (st_ds !== 1'b0 || e !== 1'b1) begin errors++;
            $display("FAIL ds_done got st_ds=%b e=%b want 0/1", st_ds, e); end
        fd = 11; wf = 1; fc = 3'b000; tick();
        checks++; if (en[AW-1:0] !== 11 || en[2*AW-1:AW] !== 3 || ew[1] !== 1'b1) begin errors++;
            $display("FAIL ds_next got e1=%0d e2=%0d ew1=%b want 11/3/1", en[AW-1:0], en[2*AW-1:AW], ew[1]); end
    endtask

    task automatic test_raw();
        logic [1:0] xf; logic xs;
        do_reset();
        fd = 7; wf = 1; fc = 3'b000; tick();
        set_idle(); use_fs = 1; fs = 7; #1;
        checks++; if (st_raw !== 1'b1) begin errors++; $display("FAIL raw_e1 got %b want 1", st_raw); end
        tick();
        checks++; if (en[AW-1:0] !== 0 || ew[0] !== 1'b0 || en[2*AW-1:AW] !== 7 || ew[1] !== 1'b1) begin errors++;
            $display("FAIL raw_bubble got e1=%0d/%b e2=%0d/%b want 0/0 7/1", en[AW-1:0], ew[0], en[2*AW-1:AW], ew[1]); end
        checks++; if (st_raw !== 1'b1) begin errors++; $display("FAIL raw_e2 got %b want 1", st_raw); end
        tick();
        use_ft = 1; ft = 7; #1;
`ifdef FPU_FWD_EN
        xs = 1'b0; xf = 2'b01;
`else
        xs = 1'b1; xf = 2'b00;
`endif
        checks++; if (st_raw !== xs || fwd_a !== xf || fwd_b !== xf) begin errors++;
            $display("FAIL raw_e3 got raw=%b fa=%b fb=%b want %b/%b", st_raw, fwd_a, fwd_b, xs, xf); end
        tick();
`ifdef FPU_FWD_EN
        xf = 2'b10;
`else
        xf = 2'b00;
`endif
        checks++; if (st_raw !== 1'b0 || fwd_a !== xf) begin errors++;
            $display("FAIL raw_w got raw=%b fa=%b want 0/%b", st_raw, fwd_a, xf); end
        set_idle(); fd = 0; wf = 1; fc = 3'b000; tick();
        set_idle(); use_ft = 1; ft = 0; #1;
        checks++; if (st_raw !== 1'b1) begin errors++; $display("FAIL raw_reg0 got %b want 1", st_raw); end
        ft = 1; #1;
        checks++; if (st_raw !== 1'b0) begin errors++; $display("FAIL raw_nomatch got %b want 0", st_raw); end
    endtask

    task automatic test_cancel_hold();
        int bad = 0;
        do_reset();
        res_in = 32'hABCD;
        fd = 9; wf = 1; fc = 3'b000; tick();
        wf = 0; fd = 0; fc = 3'b111; ein2 = 0; #1;
        checks++; if (ew[0] !== 1'b0) begin errors++; $display("FAIL cancel_ew0 got %b want 0", ew[0]); end
        tick(); ein2 = 1; tick(); tick();
        checks++; if (ww !== 1'b0 || wn !== 9) begin errors++;
            $display("FAIL cancel_wb got ww=%b wn=%0d want 0/9", ww, wn); end
        fd = 12; wf = 1; tick(); fd = 13; tick();
        set_idle(); res_in = 32'h1234; ein1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (en !== {5'd0, 5'd12, 5'd13} || ew !== 3'b011 || wd !== 32'hABCD || e !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold got %0d bad cycles want 0", bad); end
        // fdiv cancelled the cycle after issue
        do_reset();
        fc = 3'b100; fd = 4; wf = 1; tick();
        set_idle(); ein2 = 0; #1;
        checks++; if (st_ds !== 1'b1) begin errors++; $display("FAIL dscancel_pre got %b want 1", st_ds); end
        tick(); ein2 = 1; #1;
        checks++; if (st_ds !== 1'b0 || ew[0] !== 1'b0) begin errors++;
            $display("FAIL dscancel got st_ds=%b ew0=%b want 0/0", st_ds, ew[0]); end
    endtask

    task automatic test_reset_busy();
        int wbs = 0;
        do_reset();
        fd = 2; wf = 1; fc = 3'b000; tick();
        set_idle(); tick(); tick();
        fc = 3'b100; fd = 6; wf = 1; res_in = 32'h55; tick();
        set_idle();
        checks++; if (ww !== 1'b1 || wd !== 32'h55 || st_ds !== 1'b1) begin errors++;
            $display("FAIL rb_pre got ww=%b wd=%h ds=%b want 1/55/1", ww, wd, st_ds); end
        repeat (5) tick();   // divider count now 8
        clrn = 0; tick(); clrn = 1; #1;
        checks++; if (st_ds !== 1'b0 || ww !== 1'b0 || wd !== '0 || en !== '0) begin errors++;
            $display("FAIL rb_post got ds=%b ww=%b wd=%h en=%h want 0", st_ds, ww, wd, en); end
        for (int i = 0; i < 20; i++) begin tick(); if (ww) wbs++; end
        checks++; if (wbs != 0) begin errors++; $display("FAIL rb_nowb got %0d writebacks want 0", wbs); end
    endtask

    task automatic test_random();
        bit xe, xds, xraw; logic [1:0] xfa, xfb;
        logic [DEPTH*AW-1:0] xen; logic [DEPTH-1:0] xew;
        do_reset(); model_reset();
        for (int c = 0; c < 3000; c++) begin
            clrn   = ($urandom_range(0, 199) != 0);
            fs     = AW'($urandom_range(0, 7)); ft = AW'($urandom_range(0, 7));
            fd     = AW'($urandom_range(0, 7));
            use_fs = $urandom_range(0, 1); use_ft = $urandom_range(0, 1);
            wf     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) fc = $urandom_range(0, 1) ? 3'b100 : 3'b101;
            else begin fc = 3'($urandom_range(0, 7)); if (fc[2] && !fc[1]) fc = 3'b111; end
            ein1   = ($urandom_range(0, 7) != 0);
            ein2   = ($urandom_range(0, 5) != 0);
            res_in = $urandom;
            #1;
            m_comb(xe, xds, xraw, xfa, xfb);
            for (int k = 0; k < DEPTH; k++) begin
                xen[k*AW +: AW] = stg[k].dst; xew[k] = m_writes(k);
            end
            checks++; if ({e, st_ds, st_raw, fwd_a, fwd_b} !== {xe, xds, xraw, xfa, xfb}) begin errors++;
                $display("FAIL rnd_ctl c=%0d got e=%b ds=%b raw=%b fa=%b fb=%b want %b %b %b %b %b",
                         c, e, st_ds, st_raw, fwd_a, fwd_b, xe, xds, xraw, xfa, xfb); end
            checks++; if (en !== xen || ew !== xew) begin errors++;
                $display("FAIL rnd_stage c=%0d got en=%h ew=%b want %h %b", c, en, ew, xen, xew); end
            checks++; if ({wn, ww, wd} !== {m_w.dst, m_w.wr, m_wd}) begin errors++;
                $display("FAIL rnd_wb c=%0d got %0d/%b/%h want %0d/%b/%h", c, wn, ww, wd, m_w.dst, m_w.wr, m_wd); end
            model_clock();
            tick();
        end
    endtask

    initial begin
        set_idle(); clrn = 0;
        test_reset();
        test_latency();
        test_fdiv();
        test_raw();
        test_cancel_hold();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
